// File: rtl/gcd_if.sv
// Request/result bundle for gcd_core: operands and start in, FIFO-style result write out.
// Result handshake: a write happens in every cycle where wr_en_o is high; wr_en_o is only raised when full_i is low, so full_i acts as the inverse of ready.
interface gcd_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  start_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  busy_o;
  logic                  full_i;
  logic                  wr_en_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  done_o;
  logic                  zero_err_o;
  logic [7:0]            push_cnt_o;

  modport master (
    output start_i, a_i, b_i, full_i,
    input  busy_o, wr_en_o, data_o, done_o, zero_err_o, push_cnt_o
  );

  modport slave (
    input  start_i, a_i, b_i, full_i,
    output busy_o, wr_en_o, data_o, done_o, zero_err_o, push_cnt_o
  );
endinterface

// File: rtl/gcd_core.sv
// Subtractive GCD engine: accepts operands in IDLE, iterates in CALC, and writes
// one result into a downstream FIFO from PUSH, stalling while the FIFO is full.
module gcd_core #(
  parameter int DATA_WIDTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  gcd_if.slave       bus,
  output logic [1:0] dbg_state_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] PUSH = 2'd2;

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [7:0]            cnt_q;
  logic                  zero_err_q;
  logic                  wr_fire;

  assign wr_fire = (state_q == PUSH) && !bus.full_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= 8'd0;
      zero_err_q <= 1'b0;
    end else begin
      zero_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            a_q <= bus.a_i;
            b_q <= bus.b_i;
            // With a zero operand the answer is the other one; OR yields it (and 0 for 0,0).
            if ((bus.a_i == '0) || (bus.b_i == '0)) begin
              res_q      <= bus.a_i | bus.b_i;
              zero_err_q <= (bus.a_i == '0) && (bus.b_i == '0);
              state_q    <= PUSH;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (a_q == b_q) begin
            res_q   <= a_q;
            state_q <= PUSH;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        PUSH: begin
          if (wr_fire) begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o     = (state_q != IDLE);
  assign bus.wr_en_o    = wr_fire;
  assign bus.done_o     = wr_fire;
  assign bus.data_o     = res_q;
  assign bus.zero_err_o = zero_err_q;
  assign bus.push_cnt_o = cnt_q;
  assign dbg_state_o    = state_q;
endmodule

// File: doc/gcd_core.md
GCD_CORE -- requirements
Module: gcd_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: request to compute gcd(a_i, b_i); sampled only in IDLE.
REQ-005 The block SHALL have ports a_i and b_i, input, DATA_WIDTH bits each: unsigned operands, captured on an accepted start_i.
REQ-006 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-007 The block SHALL have port full_i, input, 1 bit: downstream FIFO full flag; no write is issued while it is high.
REQ-008 The block SHALL have port wr_en_o, output, 1 bit: write strobe to the downstream FIFO.
REQ-009 The block SHALL have port data_o, output, DATA_WIDTH bits: result written to the FIFO, valid when wr_en_o=1.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle pulse, high in the same cycle as the accepted write.
REQ-011 The block SHALL have port zero_err_o, output, 1 bit: one-cycle pulse, high on acceptance of start_i with a_i=0 and b_i=0.
REQ-012 The block SHALL have port push_cnt_o, output, 8 bits: count of results written.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and PUSH.
REQ-014 In IDLE with start_i=1: a_i and b_i SHALL be registered into regs A and B.
REQ-015 In IDLE with start_i=1 and either operand zero: result SHALL be the other operand (0 if both are zero), and the next state SHALL be PUSH.
REQ-016 In IDLE with start_i=1 and both operands non-zero: the next state SHALL be CALC.
REQ-017 In CALC, one step per cycle: if A==B, result<=A and next state is PUSH; else if A>B, A<=A-B; else B<=B-A.
REQ-018 All subtraction SHALL be unsigned DATA_WIDTH-bit arithmetic; no underflow can occur, because the larger operand is always the minuend.
REQ-019 wr_en_o SHALL equal (state==PUSH) && !full_i, combinationally; data_o SHALL be the registered result and SHALL hold stable throughout PUSH.
REQ-020 In PUSH with full_i=1, the block SHALL hold PUSH indefinitely with no write and no done_o.
REQ-021 In PUSH with full_i=0, the block SHALL write for exactly one cycle, pulse done_o, increment push_cnt_o, and return to IDLE.
REQ-022 push_cnt_o SHALL wrap from 255 to 0.
REQ-023 start_i SHALL be ignored while busy_o=1; there is no queuing.
REQ-024 A start_i that is high in the first IDLE cycle after a write SHALL be accepted.
REQ-025 For start accepted at edge 0, CALC SHALL occupy edges 1..k, where k = subtraction steps + 1; wr_en_o SHALL be first possible in the cycle after edge k.
REQ-026 For zero operands, wr_en_o SHALL be first possible in the cycle after edge 0.
REQ-027 Worst-case CALC length for DATA_WIDTH=4 SHALL be 15 cycles (e.g. 15,1).
REQ-028 The block SHALL produce exactly one write per accepted start, never a duplicate, and no write without a start.

Reset
REQ-029 While rst_i=1 at a clock edge, the block SHALL set state to IDLE and set A, B, result and push_cnt_o to 0.
REQ-030 After reset, busy_o, wr_en_o, done_o and zero_err_o SHALL be 0, and data_o SHALL be 0.
REQ-031 Reset in CALC or PUSH SHALL abort the operation, discard its result, and issue no write.
REQ-032 start_i coincident with rst_i SHALL be ignored.

Verification
REQ-033 Bench SHALL cover: a=12, b=8, full_i=0 -> A: 4; then B: 4; then equal; wr_en_o=1 with data_o=4 in the 4th cycle after the start edge; done_o=1; push_cnt_o=1.
REQ-034 Bench SHALL cover: a=0, b=9 -> next cycle wr_en_o=1, data_o=9, zero_err_o=0; a=0, b=0 -> zero_err_o pulses and data_o=0 is written.
REQ-035 Bench SHALL cover: a=15, b=1 with full_i held high for 5 cycles after entering PUSH -> no wr_en_o during the stall; a single write of data_o=1 in the cycle full_i drops.
REQ-036 Bench SHALL cover: a second start_i (a=6, b=4) pulsed while computing 9, 6 -> ignored; exactly one write of 3; a new start in the following IDLE cycle gives 2.
REQ-037 Bench SHALL cover: rst_i asserted mid-CALC for a=14, b=10 -> next cycle busy_o=0; no wr_en_o ever appears; push_cnt_o=0.
REQ-038 Bench SHALL cover: 256 back-to-back runs of a=5, b=5 -> push_cnt_o returns to 0; each run writes 5 exactly once.
